// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types, limits and BCD validation for the wall-clock timebase
package clock_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t SEC_MAX          = 8'h59;
    localparam bcd2_t MIN_MAX          = 8'h59;
    localparam bcd2_t HOUR_MAX         = 8'h23;
    localparam int    DIV_BITS_DEFAULT = 20;

    function automatic logic bcd2_valid(input bcd2_t value, input bcd2_t max);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit packed-BCD counter with wrap at max and synchronous load
module bcd2_counter
    import clock_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  bcd2_t max,
    input  logic  inc,
    input  logic  load,
    input  bcd2_t load_val,
    output bcd2_t q,
    output logic  carry
);

    bcd2_t q_q;
    bcd2_t q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (inc) begin
            if (q_q == max) begin
                q_d = 8'h00;
            end else if (q_q[3:0] == 4'd9) begin
                q_d = {q_q[7:4] + 4'd1, 4'd0};
            end else begin
                q_d = {q_q[7:4], q_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 8'h00;
        end else begin
            q_q <= q_d;
        end
    end

    // A load overrides counting, so it must also suppress the carry to the next stage.
    assign carry = inc & ~load & (q_q == max);
    assign q     = q_q;

endmodule

// File: rtl/clock_timebase.sv
// rtl/clock_timebase.sv - prescaler to 1 Hz, BCD hh:mm:ss keeping, time-set handshake and blink
module clock_timebase
    import clock_pkg::*;
#(
    parameter int DIV_BITS = DIV_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       run,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_err,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       tick_1hz,
    output logic       blink,
    output logic       day_pulse
);

    logic                sync1_q, sync2_q;
    logic [DIV_BITS-1:0] pre_q, pre_d;
    logic                tick_q, tick_d;
    logic                day_q, day_d;
    logic                err_q, err_d;

    logic lk, en, wrap, accept, set_ok, do_load, sec_inc;
    logic ss_carry, mm_carry, hh_carry;

    assign lk      = sync2_q;
    assign en      = lk & run;
    assign wrap    = en & (&pre_q);
    assign accept  = set_valid & lk;
    assign set_ok  = bcd2_valid(set_ss, SEC_MAX) & bcd2_valid(set_mm, MIN_MAX)
                   & bcd2_valid(set_hh, HOUR_MAX);
    assign do_load = accept & set_ok;
    // A valid load landing on the wrap edge takes priority and swallows that second.
    assign sec_inc = wrap & ~do_load;

    always_comb begin
        pre_d  = pre_q;
        tick_d = sec_inc;
        day_d  = hh_carry;
        err_d  = accept & ~set_ok;
        if (do_load) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + DIV_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            day_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            day_q   <= day_d;
            err_q   <= err_d;
        end
    end

    bcd2_counter u_ss (
        .clk      (clk),
        .rst_n    (rst_n),
        .max      (SEC_MAX),
        .inc      (sec_inc),
        .load     (do_load),
        .load_val (set_ss),
        .q        (ss),
        .carry    (ss_carry)
    );

    bcd2_counter u_mm (
        .clk      (clk),
        .rst_n    (rst_n),
        .max      (MIN_MAX),
        .inc      (ss_carry),
        .load     (do_load),
        .load_val (set_mm),
        .q        (mm),
        .carry    (mm_carry)
    );

    bcd2_counter u_hh (
        .clk      (clk),
        .rst_n    (rst_n),
        .max      (HOUR_MAX),
        .inc      (mm_carry),
        .load     (do_load),
        .load_val (set_hh),
        .q        (hh),
        .carry    (hh_carry)
    );

    assign set_ready = lk;
    assign set_err   = err_q;
    assign tick_1hz  = tick_q;
    assign day_pulse = day_q;
    assign blink     = ~pre_q[DIV_BITS-1];

endmodule
